// File: rtl/mips_if_pkg.sv
// mips_if_pkg: shared definitions for the instruction-fetch slice.
//   - ADDR_W / INST_W : bus address and instruction widths
//   - NOP_INST_DEFAULT: instruction word used at reset and on fetch abort
//   - fetch_state_t   : fetch sequencer state encoding (IDLE/REQ/DISCARD)
package mips_if_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: instruction bus between the fetch sequencer (master)
// and the instruction memory / bus slave.
//   ibus_req_o   master->slave  read request
//   ibus_addr_o  master->slave  read address
//   ibus_ack_i   slave->master  read complete, ibus_rdata_i valid this cycle
//   ibus_rdata_i slave->master  read data
//
// Handshake: once ibus_req_o rises, ibus_addr_o stays constant and
// ibus_req_o stays high until the cycle in which ibus_ack_i is sampled
// high (or a reset/timeout abandons the request). A cycle with both
// ibus_req_o and ibus_ack_i high completes exactly one read; ibus_ack_i
// while ibus_req_o is low carries no meaning.
interface if_fetch_ctrl_if;
    import mips_if_pkg::*;

    logic              ibus_req_o;
    logic [ADDR_W-1:0] ibus_addr_o;
    logic              ibus_ack_i;
    logic [INST_W-1:0] ibus_rdata_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_ack_i,
        input  ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_ack_i,
        output ibus_rdata_i
    );

endinterface

// File: rtl/fetch_timeout_cnt.sv
// fetch_timeout_cnt: counts cycles a fetch request waits for ack and flags
// expiry. Used by if_fetch_ctrl only when FETCH_TIMEOUT_EN is defined.
//   clk, rst  clock, synchronous active-high reset
//   busy_i    request outstanding (REQ or DISCARD)
//   ack_i     bus ack this cycle
//   expire_o  combinational: this is the last permitted waiting cycle
module fetch_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o
);

    // Largest value held is TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = busy_i && !ack_i && (cnt_q == CNT_LAST);

    // Leaving REQ/DISCARD happens exactly on ack or expiry, so both clear.
    always_comb begin
        cnt_d = '0;
        if (busy_i && !ack_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch sequencer between the IF-stage PC and
// the instruction bus. One read outstanding at most, 2 cycles/instruction
// minimum. Flushed fetches are completed on the bus and their data dropped.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that waits
// TIMEOUT_CYCLES cycles without ack (fetch_err_o pulse, NOP delivered).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   pc_i          fetch address from the PC register
//   ce_i          PC chip enable (low = no fetching)
//   flush_i       redirect: drop the outstanding fetch result
//   id_stall_i    stall from ID or later stages
//   ibus          instruction bus, master side
//   inst_o        fetched instruction to IF/ID
//   inst_valid_o  inst_o holds an unconsumed instruction
//   stallreq_o    freeze PC while a fetch is pending
//   fetch_err_o   one-cycle pulse on fetch timeout
//   state_o       current sequencer state (debug)
module if_fetch_ctrl
    import mips_if_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [INST_W-1:0] NOP_INST       = NOP_INST_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                ce_i,
    input  logic                flush_i,
    input  logic                id_stall_i,
    if_fetch_ctrl_if.master     ibus,
    output logic [INST_W-1:0]   inst_o,
    output logic                inst_valid_o,
    output logic                stallreq_o,
    output logic                fetch_err_o,
    output fetch_state_t        state_o
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              expire;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .busy_i   (state_q != IDLE),
        .ack_i    (ibus.ibus_ack_i),
        .expire_o (expire)
    );
`else
    // No timeout: a request waits for ack indefinitely, so err_q never sets.
    assign expire = 1'b0;
`endif

    assign ibus.ibus_req_o  = (state_q != IDLE);
    assign ibus.ibus_addr_o = addr_q;
    assign inst_o           = inst_q;
    assign inst_valid_o     = valid_q;
    assign fetch_err_o      = err_q;
    assign state_o          = state_q;

    // Only an ack in REQ (or an abort) releases the PC; an ack in DISCARD
    // completes a dead fetch, so the PC stays frozen through it.
    assign stallreq_o = ce_i && !((state_q == REQ) && ibus.ibus_ack_i) && !expire;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        // The held word is consumed by the first non-stalled cycle.
        if (valid_q && !id_stall_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ce_i && !id_stall_i) begin
                    addr_d  = pc_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ibus.ibus_ack_i) begin
                    state_d = IDLE;
                    // Flush wins over a same-cycle ack; ce_i low drops the word.
                    if (!flush_i && ce_i) begin
                        inst_d  = ibus.ibus_rdata_i;
                        valid_d = 1'b1;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (!flush_i) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b1;
                    end
                end else if (flush_i) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (ibus.ibus_ack_i) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer between the IF-stage PC register and the instruction bus. It issues one bus read per PC value and holds the PC through the stall controller until the bus acknowledges. It delivers the fetched word to the IF/ID boundary and discards responses made obsolete by a pipeline flush (branch or exception redirect). One request is outstanding at most; the minimum cost is 2 cycles per instruction.

## Interface
- TIMEOUT_CYCLES, 255: cycles a request may wait for ack before abort (only with FETCH_TIMEOUT_EN); must be ≥1.
- NOP_INST, 32'h0000_0000: value driven on inst_o at reset and on abort.

Ports:
- clk  in  1  clock; reset rst, synchronous, active-high; all state changes on posedge clk.
- rst  in  1  reset; synchronous, active-high.
- pc_i  in  32  current fetch address from PC register.
- ce_i  in  1  PC chip enable; low = no fetching.
- flush_i  in  1  redirect this cycle; outstanding fetch result must be dropped.
- id_stall_i  in  1  stall from ID or later stages, excluding this block's own request.
- ibus_req_o  out  1  bus read request.
- ibus_addr_o  out  32  registered request address.
- ibus_ack_i  in  1  bus read done; ibus_rdata_i valid this cycle.
- ibus_rdata_i  in  32  read data.
- inst_o  out  32  fetched instruction to IF/ID.
- inst_valid_o  out  1  inst_o holds an unconsumed instruction.
- stallreq_o  out  1  to stall controller; high freezes PC (stall[0]).
- fetch_err_o  out  1  one-cycle pulse on fetch timeout.

## Operation
- States: IDLE, REQ, DISCARD.
- IDLE: ibus_req_o=0. If ce_i && !id_stall_i: addr_q<=pc_i, go REQ. Otherwise stay.
- REQ: ibus_req_o=1, ibus_addr_o=addr_q, held stable until ack.
  - ack && !flush_i: inst_o<=ibus_rdata_i, inst_valid_o<=1, go IDLE.
  - ack && flush_i: data dropped, go IDLE.
  - !ack && flush_i: go DISCARD.
- DISCARD: request stays asserted with unchanged address. On ack: data dropped, go IDLE. A further flush_i has no extra effect.
- inst_valid_o clears on the first cycle after capture where id_stall_i=0. inst_o and inst_valid_o are held while id_stall_i=1.
- stallreq_o is combinational: ce_i && !(state==REQ && ibus_ack_i). The PC therefore advances exactly on the accepted-ack edge. In DISCARD, stallreq_o stays high through the ack cycle.
- ce_i low while in REQ/DISCARD: handshake completes, data dropped, return to IDLE.
- Reset: state=IDLE, ibus_req_o=0, ibus_addr_o=0, inst_o=NOP_INST, inst_valid_o=0, fetch_err_o=0, timeout count=0.
- Reset mid-request drops ibus_req_o the next cycle. The bus slave must tolerate the abandoned request.

## Timing
- Zero-wait bus (ack in first REQ cycle): issue at T, ack at T+1, inst_valid_o=1 at T+2, next issue at T+2.
- Each wait cycle without ack adds one cycle. ibus_addr_o never changes while ibus_req_o=1.
- flush_i and ack in the same cycle: flush wins; no inst_valid_o.
- Issue is never blocked by inst_valid_o. The issue condition !id_stall_i guarantees the prior word is consumed before the next ack.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter increments each cycle in REQ/DISCARD without ack and clears on leaving those states.
  - When count==TIMEOUT_CYCLES-1 with no ack: req drops next cycle, go IDLE, fetch_err_o pulses 1 cycle, inst_o<=NOP_INST, inst_valid_o<=1 (unless flushed). stallreq_o is low in that cycle.
- FETCH_TIMEOUT_EN undefined: no counter, fetch_err_o tied 0, waits indefinitely, TIMEOUT_CYCLES ignored.

## Structure
- Shared package mips_if_pkg:
  - fetch state enum typedef (IDLE/REQ/DISCARD).
  - NOP_INST default constant.
  - 32-bit address/instruction width constants.
- One sub-module: fetch_timeout_cnt (counter + expiry compare), instantiated only under FETCH_TIMEOUT_EN.

## Test plan
- Reset, then ce_i=1, pc_i=8000_0000, ack every first REQ cycle: requests to 8000_0000, 8000_0004 every 2 cycles; inst_o matches rdata; stallreq_o low only in ack cycles.
- Ack delayed 3 cycles: ibus_addr_o stable for 4 REQ cycles; stallreq_o high for 3 cycles, low on ack; inst_valid_o 1 cycle later.
- flush_i in second REQ cycle, ack in fourth: state DISCARD, rdata dropped, inst_valid_o stays 0, next request uses new pc_i (e.g. 8000_0100).
- id_stall_i=1 after capture of 0x2408_0001: inst_o/inst_valid_o held; no new request until id_stall_i falls.
- rst asserted while REQ waiting: next cycle ibus_req_o=0, inst_o=0, inst_valid_o=0, state IDLE.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never given: after 4 REQ cycles req drops, fetch_err_o pulses once, inst_o=NOP_INST valid.
